// File: rtl/qarma_diffusion_sequencer.sv
// Iterative QARMA diffusion sequencer: applies N rounds of
// state <= MixColumns(state) ^ rk[round], one round per clock, between a
// valid/ready input handshake and a valid/ready output handshake.
module qarma_diffusion_sequencer #(
  parameter int          N_BITS     = 128,
  parameter logic [11:0] ABC        = 12'h145,
  parameter int          MAX_ROUNDS = 15,
  parameter int          CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  input  logic [CNT_W-1:0]  in_rounds,
  output logic [CNT_W-1:0]  rk_idx,
  input  logic [N_BITS-1:0] rk_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              busy
);

  localparam int M_BITS = N_BITS / 16;
  // Rotation amounts reduced modulo the cell width; 0 means identity.
  localparam int ROT_A  = int'(ABC[11:8]) % M_BITS;
  localparam int ROT_B  = int'(ABC[7:4]) % M_BITS;
  localparam int ROT_C  = int'(ABC[3:0]) % M_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              fsm_q;
  logic [N_BITS-1:0]   state_q;
  logic [N_BITS-1:0]   out_data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    target_q;
  logic                out_valid_q;

  logic [N_BITS-1:0]   mix;
  logic [N_BITS-1:0]   round_d;
  logic [CNT_W-1:0]    in_target;

  // Circular left rotation within one cell; amt is already in [0, M_BITS).
  function automatic logic [M_BITS-1:0] rotl(input logic [M_BITS-1:0] x, input int amt);
    logic [2*M_BITS-1:0] dbl;
    logic [2*M_BITS-1:0] shf;
    dbl = {x, x};
    shf = dbl >> (M_BITS - amt);
    return shf[M_BITS-1:0];
  endfunction

  // One MixColumns cell per generate iteration: cell k sits at row k/4,
  // column k%4, MSB-first; each output cell mixes the other three cells of
  // its column.
  for (genvar gi = 0; gi < 16; gi++) begin : g_mix
    localparam int ROW = gi / 4;
    localparam int COL = gi % 4;
    localparam int K1  = ((ROW + 1) % 4) * 4 + COL;
    localparam int K2  = ((ROW + 2) % 4) * 4 + COL;
    localparam int K3  = ((ROW + 3) % 4) * 4 + COL;

    assign mix[N_BITS-1-gi*M_BITS -: M_BITS] =
        rotl(state_q[N_BITS-1-K1*M_BITS -: M_BITS], ROT_A) ^
        rotl(state_q[N_BITS-1-K2*M_BITS -: M_BITS], ROT_B) ^
        rotl(state_q[N_BITS-1-K3*M_BITS -: M_BITS], ROT_C);
  end

  assign round_d   = mix ^ rk_data;
  // Oversized requests are clamped so the counter can never wrap.
  assign in_target = (in_rounds > CNT_W'(MAX_ROUNDS)) ? CNT_W'(MAX_ROUNDS) : in_rounds;

  // Control FSM plus datapath registers; outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= in_data;
            cnt_q    <= '0;
            target_q <= in_target;
            if (in_target == '0) begin
              fsm_q       <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
            end else begin
              fsm_q <= RUN;
            end
          end
        end
        RUN: begin
          state_q <= round_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == target_q - CNT_W'(1)) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= round_d;
          end
        end
        DONE: begin
          // Result is held for as long as the consumer stalls.
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps in_ready low while reset is asserted.
  assign in_ready  = rst_n & (fsm_q == IDLE);
  assign busy      = (fsm_q != IDLE);
  assign rk_idx    = (fsm_q == RUN) ? cnt_q : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_qarma_diffusion_sequencer.sv
// Directed bench for qarma_diffusion_sequencer: default build plus a
// MAX_ROUNDS=10 build for the clamp check.
module tb_qarma_diffusion_sequencer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_rounds;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic         in_valid10;
  logic         in_ready10;
  logic [3:0]   rk_idx10;
  logic [127:0] rk_data10;
  logic         out_valid10;
  logic [127:0] out_data10;
  logic         busy10;

  logic         key_mode;
  int           n_checks;
  int           n_pass;
  int           hs_count;
  logic [63:0]  seq;
  logic [3:0]   last_rk;

  qarma_diffusion_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rounds(in_rounds), .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  qarma_diffusion_sequencer #(.MAX_ROUNDS(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
    .in_data(in_data), .in_rounds(in_rounds), .rk_idx(rk_idx10), .rk_data(rk_data10),
    .out_valid(out_valid10), .out_ready(out_ready), .out_data(out_data10), .busy(busy10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-key store stand-in: key = index replicated across the state.
  always_comb begin
    rk_data   = key_mode ? {32{rk_idx}} : 128'h0;
    rk_data10 = {32{rk_idx10}};
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) hs_count++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [7:0]   cells [4][4];
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        cells[row][col] = s[127-8*(4*row+col) -: 8];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[127-8*(4*row+col) -: 8] = rl(cells[(row+1)%4][col], 1) ^
                                    rl(cells[(row+2)%4][col], 4) ^
                                    rl(cells[(row+3)%4][col], 5);
    return r;
  endfunction

  function automatic logic [127:0] ref_keyed(input int rounds);
    logic [127:0] s;
    logic [3:0]   k;
    s = '0;
    for (int i = 0; i < rounds; i++) begin
      k = i[3:0];
      s = ref_mix(s) ^ {32{k}};
    end
    return s;
  endfunction

  // Runs one job on the default build with out_ready=1; returns the
  // result and the number of edges after the accept edge until out_valid.
  task automatic do_job(input logic [127:0] d, input logic [3:0] n,
                        output logic [127:0] res, output int edges);
    @(negedge clk);
    in_data   = d;
    in_rounds = n;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 0;
    seq   = 64'h1;
    @(negedge clk);
    while (!out_valid && edges < 40) begin
      seq = {seq[59:0], rk_idx};
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!out_valid) chk("job_timeout", 128'(out_valid), 128'd1);
    res     = out_data;
    last_rk = rk_idx;
    @(posedge clk);
    @(negedge clk);
    chk("post_out_valid", 128'(out_valid), 128'd0);
    chk("post_in_ready", 128'(in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] rnd;
    logic [127:0] held;
    int           edges;
    int           bad;
    int           hs0;

    n_checks = 0; n_pass = 0; hs_count = 0;
    key_mode = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_valid10 = 1'b0; out_ready = 1'b1;
    in_data = '0; in_rounds = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'd1);

    // Single round on a one-hot cell
    do_job(128'h00000000_01000000_00000000_00000000, 4'd1, res, edges);
    chk("one_round_data", res, 128'h02000000_00000000_20000000_10000000);
    chk("one_round_lat", 128'(edges), 128'd1);

    // Involution: 2 and 4 rounds with zero keys return the input
    rnd = {$urandom, $urandom, $urandom, $urandom};
    do_job(rnd, 4'd2, res, edges);
    chk("inv2_data", res, rnd);
    chk("inv2_rk_seq", 128'(seq), 128'h101);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    do_job(rnd, 4'd4, res, edges);
    chk("inv4_data", res, rnd);
    chk("inv4_rk_seq", 128'(seq), 128'h10123);
    chk("inv4_lat", 128'(edges), 128'd4);

    // Zero rounds: passthrough, result right after the accept edge
    do_job({4{32'hDEADBEEF}}, 4'd0, res, edges);
    chk("zero_data", res, {4{32'hDEADBEEF}});
    chk("zero_lat", 128'(edges), 128'd0);
    chk("zero_rk_idx", 128'(last_rk), 128'd0);

    // Key injection over the full 15 rounds
    key_mode = 1'b1;
    do_job(128'h0, 4'd15, res, edges);
    chk("key15_data", res, ref_keyed(15));
    chk("key15_lat", 128'(edges), 128'd15);
    key_mode = 1'b0;

    // Clamp: MAX_ROUNDS=10 build runs only 10 rounds for a 15-round request
    @(negedge clk);
    in_data = 128'h0; in_rounds = 4'd15; in_valid10 = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid10 = 1'b0;
    edges = 0;
    @(negedge clk);
    while (!out_valid10 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("clamp10_lat", 128'(edges), 128'd10);
    chk("clamp10_data", out_data10, ref_keyed(10));
    @(posedge clk);
    @(negedge clk);
    chk("clamp10_idle", 128'(in_ready10), 128'd1);

    // Backpressure: 20 stalled cycles in DONE with in_valid held high
    rnd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_data = rnd; in_rounds = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 0;
    @(negedge clk);
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    held = out_data;
    chk("bp_data", held, ref_mix(rnd));
    in_valid = 1'b1;
    in_data  = ~rnd;
    in_rounds = 4'd1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("bp_stall_bad_cycles", 128'(bad), 128'd0);
    hs0 = hs_count;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_data", out_data, held);
    repeat (3) @(negedge clk);
    chk("bp_handshakes", 128'(hs_count - hs0), 128'd1);
    chk("bp_idle_busy", 128'(busy), 128'd0);

    // Reset mid-job at cnt=3 of a 10-round job
    rnd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_data = rnd; in_rounds = 4'd10; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 0;
    @(negedge clk);
    while (rk_idx != 4'd3 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("midrst_reach_cnt3", 128'(rk_idx), 128'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_out_data", out_data, 128'h0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    do_job(rnd, 4'd2, res, edges);
    chk("after_rst_job", res, rnd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qarma_diffusion_sequencer.md
Name: qarma_diffusion_sequencer

Overview:
- Iterative controller around one 128-bit QARMA diffusion-matrix datapath.
- Accepts a 128-bit state over a valid/ready handshake.
- Applies N rounds of state <= MixColumns(state) XOR rk[round], one round per clock. Round keys are fetched over an indexed lookup port.
- Returns the result over a valid/ready handshake with backpressure.
- Sits between the key-schedule/tweak store and the round-function pipeline of the QARMA-128 core.

Parameters:
- N_BITS, 128, state width; cell width M_BITS = N_BITS/16.
- ABC, 12'h145, rotation amounts {A,B,C}, 4 bits each, MSB nibble = A. Default gives circ(0,rho^1,rho^4,rho^5).
- MAX_ROUNDS, 15, maximum rounds per job.
- CNT_W, 4, round-counter width. Must satisfy 2^CNT_W > MAX_ROUNDS.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  job request
- in_ready  out  1  sequencer can accept a job
- in_data  in  N_BITS  initial state
- in_rounds  in  CNT_W  rounds to apply
- rk_idx  out  CNT_W  round-key index being requested
- rk_data  in  N_BITS  round key for rk_idx, combinational, same cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  N_BITS  result state
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset: synchronous, active-low; the only reset behaviour is on clk edges with rst_n=0. It forces state IDLE, out_valid=0, out_data=0, rk_idx=0, counter=0, busy=0, in_ready=0 during reset. Reset mid-RUN or mid-DONE discards the job with no output.
- Cell map: cell k = state[N_BITS-1-k*M_BITS -: M_BITS], k=0..15, MSB-first. Row r=k/4, column c=k%4.
- MixColumns: out[r][c] = rotl(in[(r+1)%4][c],A) ^ rotl(in[(r+2)%4][c],B) ^ rotl(in[(r+3)%4][c],C).
  - rotl is a circular left rotation within M_BITS.
  - Rotation amounts are taken mod M_BITS; an amount of 0 is identity.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state_reg<=in_data, cnt<=0, target<=min(in_rounds,MAX_ROUNDS).
  - Go to DONE if target=0, else RUN.
- RUN:
  - rk_idx=cnt. Each edge: state_reg <= MixColumns(state_reg) ^ rk_data, cnt<=cnt+1.
  - The edge with cnt=target-1 moves to DONE.
  - in_ready=0. in_valid is ignored and not queued.
- DONE:
  - out_valid=1 and out_data=state_reg.
  - Both hold stable while out_ready=0, for an unbounded stall.
  - On out_valid&out_ready: go to IDLE and set out_valid=0. out_data retains its last value.
  - in_ready stays 0 in DONE; there is no same-cycle turnaround.
- Latency: with the input handshake on edge E0, out_valid is first high after edge E0+target (E0 when target=0).
- Throughput: one job per target+2 cycles when out_ready=1.
- rk_idx outside RUN: holds 0. rk_data is ignored outside RUN.
- Counter: CNT_W-bit, never wraps; in_rounds>MAX_ROUNDS is clamped.
- busy = (state != IDLE).
- Only one datapath instance exists; it is combinational between state_reg and the XOR with rk_data.

Test Plan:
- Reset, then single round. in_data = cell4=0x01 (bits 95:88), other cells zero; rk_data=0; in_rounds=1. Required after 2 edges: out_data = cell0=0x02, cell8=0x20, cell12=0x10, rest 0.
- Involution, default ABC. Random in_data, in_rounds=2, rk_data=0 → out_data==in_data. Random in_data, in_rounds=4, rk_data=0 → out_data==in_data. Check rk_idx sequence 0,1 and 0,1,2,3.
- Zero rounds. in_rounds=0, in_data=0xDEADBEEF...(128b) → out_valid after 1 edge, out_data==in_data, rk_idx stays 0.
- Key injection and clamp.
  - rk_data = {rk_idx replicated}; in_data=0; in_rounds=15 → out_data matches the reference model.
  - Same job with in_rounds=15 (4-bit max, also MAX_ROUNDS) and with MAX_ROUNDS=10 → the 10-param build clamps to 10 rounds.
- Backpressure. Hold out_ready=0 for 20 cycles in DONE, with in_valid=1 throughout → out_data stable, in_ready=0, no job accepted. Release → exactly one handshake, then IDLE and in_ready=1.
- Reset mid-job. Assert rst_n=0 for one edge at cnt=3 of a 10-round job → next cycle IDLE, out_valid=0, out_data=0, busy=0. A subsequent job completes correctly.
